pll_mgmt_responder: RTL and testbench

Avalon-MM management-port responder for the video PLL's reconfiguration interface. It is the slave end of the mgmt bus driven by the top-level underclock sequencer. It accepts mode, fractional-K and start writes, and holds `mgmt_waitrequest` while a reconfiguration is in progress. It then applies the new K value to its output with a one-cycle `apply` strobe. It is the bench and stand-in target for the sequencer, and it carries the register/handshake semantics the sequencer relies on.

---
 rtl/pll_mgmt_responder.sv | 164 ++++++++++++++++
 tb/tb_pll_mgmt_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_mgmt_responder.sv
// ---------------------------------------------------------------------------
// pll_mgmt_responder
//
// Avalon-MM slave that stands in for the video PLL reconfiguration port.
// Accepts MODE / START / K register writes from the underclock sequencer,
// stalls the bus (waitrequest mode) or exposes a STATUS bit (polling mode)
// while a reconfiguration is in progress, then applies the pending K value
// to frac_k with a one-cycle apply strobe.
//
// Register map:
//   0 MODE   bit0 r/w (0 = waitrequest mode, 1 = polling mode)
//   1 STATUS bit0 = ~busy, read-only
//   2 START  write-only, any data starts a reconfiguration
//   7 K      r/w pending K (not the applied frac_k)
//   others   writes ignored, reads return 0
//
// Ports:
//   mgmt_clk          sole clock
//   mgmt_reset        synchronous, active-high reset
//   mgmt_write        write request
//   mgmt_read         read request
//   mgmt_address[5:0] register address
//   mgmt_writedata    write data
//   mgmt_readdata     registered read data, latency 1, held between reads
//   mgmt_waitrequest  stall, high only in BUSY while MODE = 0
//   frac_k            applied fractional-K value
//   apply             one-cycle strobe in the cycle frac_k takes its new value
//   busy              high while the reconfiguration is in progress
// ---------------------------------------------------------------------------
module pll_mgmt_responder #(
    parameter int unsigned BUSY_CYCLES = 16,
    parameter logic [31:0] RESET_K     = 32'd3639383488
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset,
    input  logic        mgmt_write,
    input  logic        mgmt_read,
    input  logic [5:0]  mgmt_address,
    input  logic [31:0] mgmt_writedata,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic [31:0] frac_k,
    output logic        apply,
    output logic        busy
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_K      = 6'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [31:0]        r_pend_k;
    logic [31:0]        r_frac_k;
    logic [31:0]        r_rdata;

    logic               w_wreq;
    logic               w_busy;
    logic               w_apply;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [31:0]        w_rd_mux;

    // Acceptance: a write wins over a simultaneous read, which is dropped.
    assign w_wr_acc = mgmt_write & ~w_wreq;
    assign w_rd_acc = mgmt_read & ~mgmt_write & ~w_wreq;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_apply     = 1'b0;
        w_wreq      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_wr_acc && (mgmt_address == ADDR_START)) begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                w_wreq = ~r_mode;
                // Counter was loaded with BUSY_CYCLES, so leaving at 1 gives
                // exactly BUSY_CYCLES cycles in this state.
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (mgmt_address)
            ADDR_MODE:   w_rd_mux = {31'd0, r_mode};
            ADDR_STATUS: w_rd_mux = {31'd0, ~w_busy};
            ADDR_K:      w_rd_mux = r_pend_k;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge mgmt_clk) begin
        if (mgmt_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_pend_k <= RESET_K;
            r_frac_k <= RESET_K;
            r_rdata  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == S_IDLE) && (w_state_nxt == S_BUSY)) begin
                r_cnt <= CNT_W'(BUSY_CYCLES);
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            // frac_k is loaded on entry to APPLY so the strobe and the new
            // value appear together; a K write landing in the APPLY cycle
            // therefore only reaches the pending register.
            if ((r_state == S_BUSY) && (w_state_nxt == S_APPLY)) begin
                r_frac_k <= r_pend_k;
            end

            if (w_wr_acc) begin
                if (mgmt_address == ADDR_MODE) begin
                    r_mode <= mgmt_writedata[0];
                end
                if (mgmt_address == ADDR_K) begin
                    r_pend_k <= mgmt_writedata;
                end
            end

            if (w_rd_acc) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign mgmt_readdata    = r_rdata;
    assign mgmt_waitrequest = w_wreq;
    assign frac_k           = r_frac_k;
    assign apply            = w_apply;
    assign busy             = w_busy;

endmodule

// File: tb/tb_pll_mgmt_responder.sv
module tb_pll_mgmt_responder;

    localparam int          BC  = 16;
    localparam logic [31:0] RK  = 32'd3639383488;
    localparam logic [31:0] SEQ_K = 32'd3262113561;

    logic        clk = 1'b0;
    logic        mgmt_reset = 1'b1;
    logic        mgmt_write = 1'b0;
    logic        mgmt_read = 1'b0;
    logic [5:0]  mgmt_address = 6'd0;
    logic [31:0] mgmt_writedata = 32'd0;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic [31:0] frac_k;
    logic        apply;
    logic        busy;

    always #5 clk = ~clk;

    pll_mgmt_responder #(
        .BUSY_CYCLES (BC),
        .RESET_K     (RK)
    ) dut (
        .mgmt_clk         (clk),
        .mgmt_reset       (mgmt_reset),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .frac_k           (frac_k),
        .apply            (apply),
        .busy             (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: timestamp based. e counts clock edges; a start
    // accepted at edge m_start makes the block busy after edges
    // m_start .. m_start+BC-1 and applying after edge m_start+BC.
    int          e          = 0;
    int          m_start    = -1;
    logic        m_mode     = 1'b0;
    logic [31:0] m_pend     = RK;
    logic [31:0] m_frac     = RK;
    logic [31:0] m_rd       = 32'd0;
    int          apply_seen = 0;
    int          last_apply_e = -1;

    function automatic logic m_busy(input int ee, input int st);
        return (st >= 0) && (ee >= st) && (ee - st < BC);
    endfunction

    function automatic logic m_apply(input int ee, input int st);
        return (st >= 0) && (ee == st + BC);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs currently driven,
    // then compare every output against it.
    task automatic cycle();
        logic bz, ap, wreq, wacc, racc;
        bz   = m_busy(e, m_start);
        ap   = m_apply(e, m_start);
        wreq = bz && !m_mode;
        wacc = mgmt_write && !wreq;
        racc = mgmt_read && !mgmt_write && !wreq;
        @(posedge clk);
        if (mgmt_reset) begin
            m_mode  = 1'b0;
            m_pend  = RK;
            m_frac  = RK;
            m_rd    = 32'd0;
            m_start = -1;
        end else begin
            if (m_start >= 0 && e + 1 == m_start + BC) m_frac = m_pend;
            if (racc) begin
                case (mgmt_address)
                    6'd0:    m_rd = {31'd0, m_mode};
                    6'd1:    m_rd = {31'd0, !bz};
                    6'd7:    m_rd = m_pend;
                    default: m_rd = 32'd0;
                endcase
            end
            if (wacc) begin
                case (mgmt_address)
                    6'd0: m_mode = mgmt_writedata[0];
                    6'd7: m_pend = mgmt_writedata;
                    6'd2: if (!bz && !ap) m_start = e + 1;
                    default: ;
                endcase
            end
        end
        e++;
        #1;
        chk("busy",        {31'd0, busy},             {31'd0, m_busy(e, m_start)});
        chk("apply",       {31'd0, apply},            {31'd0, m_apply(e, m_start)});
        chk("waitrequest", {31'd0, mgmt_waitrequest}, {31'd0, m_busy(e, m_start) && !m_mode});
        chk("frac_k",      frac_k,                    m_frac);
        chk("readdata",    mgmt_readdata,             m_rd);
        if (apply === 1'b1) begin
            apply_seen++;
            last_apply_e = e;
        end
    endtask

    task automatic idle(input int n);
        mgmt_write = 1'b0;
        mgmt_read  = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        int g;
        g = 0;
        mgmt_write = 1'b0;
        mgmt_read  = 1'b0;
        while (mgmt_waitrequest === 1'b1 && g < 100) begin
            cycle();
            g++;
        end
        chk("wr_wait_timeout", g, (g < 100) ? g : 99);
        mgmt_address   = a;
        mgmt_writedata = d;
        mgmt_write     = 1'b1;
        cycle();
        mgmt_write = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        mgmt_address = a;
        mgmt_read    = 1'b1;
        cycle();
        mgmt_read = 1'b0;
    endtask

    initial begin
        int t0, ap0, wq, zeros, g;
        logic [31:0] st [20];
        logic [31:0] held;

        // Reset state
        mgmt_reset = 1'b1;
        cycle();
        cycle();
        mgmt_reset = 1'b0;
        chk("rst_frac_k", frac_k, RK);
        chk("rst_waitreq", {31'd0, mgmt_waitrequest}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_apply", {31'd0, apply}, 32'd0);
        chk("rst_readdata", mgmt_readdata, 32'd0);
        rd(6'd7);
        chk("rst_pend_k", mgmt_readdata, RK);

        // Sequencer replay in waitrequest mode
        wr(6'd0, 32'd0);
        wr(6'd7, SEQ_K);
        wr(6'd2, 32'd0);
        ap0 = apply_seen;
        wq  = int'(mgmt_waitrequest);
        for (int i = 0; i < 40; i++) begin
            cycle();
            wq += int'(mgmt_waitrequest);
        end
        chk("replay_wait_cycles", wq, BC);
        chk("replay_apply_count", apply_seen - ap0, 1);
        chk("replay_frac_k", frac_k, SEQ_K);

        // Reset in the middle of BUSY aborts
        wr(6'd2, 32'd0);
        idle(4);
        mgmt_reset = 1'b1;
        idle(3);
        mgmt_reset = 1'b0;
        ap0 = apply_seen;
        idle(30);
        chk("midrst_apply_count", apply_seen - ap0, 0);
        chk("midrst_frac_k", frac_k, RK);
        chk("midrst_waitreq", {31'd0, mgmt_waitrequest}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);

        // Polling mode: STATUS reads 0 while busy, then 1
        wr(6'd0, 32'd1);
        wr(6'd2, 32'd0);
        t0  = e;
        ap0 = apply_seen;
        wq  = 0;
        for (int i = 0; i < 20; i++) begin
            rd(6'd1);
            st[i] = mgmt_readdata;
            wq += int'(mgmt_waitrequest);
        end
        zeros = 0;
        for (int i = 0; i < 16; i++) if (st[i] == 32'd0) zeros++;
        chk("poll_status_zero_reads", zeros, 16);
        chk("poll_status_done", st[16], 32'd1);
        chk("poll_waitreq_seen", wq, 0);
        chk("poll_apply_count", apply_seen - ap0, 1);
        chk("poll_apply_edge", last_apply_e - t0, BC);
        idle(3);

        // Second start during BUSY is ignored
        wr(6'd2, 32'd0);
        t0  = e;
        ap0 = apply_seen;
        idle(4);
        wr(6'd2, 32'd0);
        idle(30);
        chk("restart_apply_count", apply_seen - ap0, 1);
        chk("restart_apply_edge", last_apply_e - t0, BC);

        // K writes during BUSY and in the APPLY cycle
        wr(6'd2, 32'd0);
        idle(2);
        wr(6'd7, 32'd5);
        g = 0;
        while (apply !== 1'b1 && g < 100) begin
            cycle();
            g++;
        end
        chk("kwr_apply_timeout", {31'd0, apply}, 32'd1);
        chk("kwr_frac_k_at_apply", frac_k, 32'd5);
        wr(6'd7, 32'd9);
        chk("kwr_frac_k_after", frac_k, 32'd5);
        rd(6'd7);
        chk("kwr_pend_k", mgmt_readdata, 32'd9);

        // Read behaviour
        wr(6'd7, 32'hCAFEF00D);
        rd(6'd7);
        chk("rd_pend_k", mgmt_readdata, 32'hCAFEF00D);
        held = mgmt_readdata;
        mgmt_address   = 6'd7;
        mgmt_writedata = 32'h0000_1234;
        mgmt_write     = 1'b1;
        mgmt_read      = 1'b1;
        cycle();
        mgmt_write = 1'b0;
        mgmt_read  = 1'b0;
        chk("rdwr_readdata_held", mgmt_readdata, held);
        rd(6'd7);
        chk("rdwr_pend_k", mgmt_readdata, 32'h0000_1234);
        rd(6'd63);
        chk("rd_addr63", mgmt_readdata, 32'd0);
        rd(6'd0);
        chk("rd_mode", mgmt_readdata, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            int sel;
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: mgmt_address = 6'd0;
                1: mgmt_address = 6'd1;
                2: mgmt_address = 6'd2;
                3: mgmt_address = 6'd7;
                default: mgmt_address = 6'($urandom_range(0, 63));
            endcase
            mgmt_writedata = $urandom;
            mgmt_write     = ($urandom_range(0, 2) == 0);
            mgmt_read      = ($urandom_range(0, 1) == 0);
            mgmt_reset     = ($urandom_range(0, 149) == 0);
            cycle();
        end
        mgmt_reset = 1'b0;
        idle(BC + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
